ps2_rx_fifo: RTL and testbench

- PS/2 device-to-host receiver for the keyboard path, sitting directly upstream of the scancode-decoding logic.
- Synchronises ps2_clk/ps2_data into the system clock domain and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Validates each frame and buffers good bytes in a small FIFO.
- Presents the FIFO head through a ready / nextdata_n pop handshake, with sticky overflow reporting.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_rx_fifo_sync_fifo.sv | 65 ++++++
 rtl/ps2_rx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receive path.
//   PS2_FRAME_BITS : bits per device-to-host frame (start, 8 data, parity, stop)
//   PS2_START/STOP : required levels of the framing bits
//   rx_state_t     : receive FSM state encoding
//   frame_ok()     : framing + odd-parity validity of a captured frame
//                    (bit 0 = start, bits 8:1 = data LSB-first, 9 = parity, 10 = stop)
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic        PS2_START      = 1'b0;
  localparam logic        PS2_STOP       = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK
  } rx_state_t;

  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[0] == PS2_START) &&
           (f[PS2_FRAME_BITS-1] == PS2_STOP) &&
           (^f[PS2_FRAME_BITS-2:1]);
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock byte FIFO with synchronous active-high clear.
//   clk, clr : clock and synchronous reset (clears pointers, count and storage)
//   push     : write wdata; honoured when not full, or when full with a pop
//              in the same cycle
//   pop      : advance the read pointer; ignored while empty
//   wdata    : write data
//   head     : storage at the read pointer (combinational)
//   full     : count == DEPTH
//   empty    : count == 0
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned     AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // When full, a same-cycle pop frees the slot being written.
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a scancode FIFO.
// Synchronises ps2_clk/ps2_data, deserialises 11-bit frames on ps2_clk
// falling edges, validates start/parity/stop and buffers good bytes.
//   clk, clr    : system clock, synchronous active-high reset
//   ps2_clk     : raw PS/2 clock (asynchronous)
//   ps2_data    : raw PS/2 data (asynchronous)
//   nextdata_n  : active-low pop; one byte per low cycle while ready
//   data        : FIFO head byte, meaningful while ready=1
//   ready       : FIFO non-empty
//   overflow    : sticky, a good frame arrived while the FIFO was full
//   frame_err   : one-cycle pulse per discarded frame
// Optional: define PS2_RX_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYCLES clk cycles without a ps2_clk falling edge.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("ps2_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_chk
    $error("ps2_rx_fifo: TIMEOUT_CYCLES must be non-zero");
  end

  // Synchroniser: two flops per input plus an edge-detect flop on the clock.
  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  always_ff @(posedge clk) begin
    if (clr) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev && !clk_s2;

  // Receive FSM.
  rx_state_t                 state, state_next;
  logic [3:0]                bit_cnt, bit_cnt_next;
  logic [PS2_FRAME_BITS-1:0] shreg, shreg_next;
  logic                      good_frame;
  logic                      bad_frame;
  logic                      timeout_err;
  logic                      timeout_hit;

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shreg   <= shreg_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    good_frame   = 1'b0;
    bad_frame    = 1'b0;
    timeout_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          shreg_next   = {data_s2, shreg[PS2_FRAME_BITS-1:1]};
          bit_cnt_next = 4'd1;
          state_next   = ST_RECV;
        end
      end
      ST_RECV: begin
        if (fall) begin
          shreg_next = {data_s2, shreg[PS2_FRAME_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_next = '0;
            state_next   = ST_CHECK;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end else if (timeout_hit) begin
          bit_cnt_next = '0;
          state_next   = ST_IDLE;
          timeout_err  = 1'b1;
        end
      end
      ST_CHECK: begin
        good_frame = frame_ok(shreg);
        bad_frame  = !frame_ok(shreg);
        state_next = ST_IDLE;
      end
      default: begin
        bit_cnt_next = '0;
        state_next   = ST_IDLE;
      end
    endcase
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Counts cycles since the last falling edge while a frame is open.
  always_ff @(posedge clk) begin
    if (clr || state != ST_RECV || fall) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Byte FIFO and status.
  logic fifo_full;
  logic fifo_empty;
  logic pop_req;

  assign pop_req = !nextdata_n;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (good_frame),
    .wdata (shreg[8:1]),
    .pop   (pop_req),
    .head  (data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready = !fifo_empty;

  always_ff @(posedge clk) begin
    if (clr) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Full FIFO with a same-cycle pop accepts the byte, so no overflow.
      if (good_frame && fifo_full && !pop_req) begin
        overflow <= 1'b1;
      end
      frame_err <= bad_frame || timeout_err;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TO = 300;
`else
  localparam int unsigned TO = 50000;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         err_pulses = 0;
  logic [7:0] exp_q[$];
  bit         pop_enable = 0;
  bit         special_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the DUT when asked and scores each popped byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (frame_err === 1'b1) err_pulses++;
      if (clr) begin
        nextdata_n = 1'b1;
      end else if (ready === 1'b1 && (pop_enable || special_pop)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got byte %0h expected no byte", data);
        end else begin
          checks--;
          e = exp_q.pop_front();
          chk("pop_data", {24'h0, data}, {24'h0, e});
        end
        nextdata_n  = 1'b0;
        special_pop = 0;
      end else begin
        nextdata_n = 1'b1;
        if (special_pop) begin
          special_pop = 0;
          chk("ready_at_check_pop", {31'h0, ready}, 32'd1);
        end
      end
    end
  end

  task automatic ps2_bit(input logic b, input bit last, input bit chk_lat, input bit pop_chk);
    @(negedge clk);
    ps2_data = b;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    if (last) begin
      // The frame is checked 3 cycles after the falling edge is driven.
      repeat (3) @(negedge clk);
      if (chk_lat) chk("ready_before_write", {31'h0, ready}, 32'd0);
      if (pop_chk) special_pop = 1;
      @(negedge clk);
      if (chk_lat) chk("ready_latency", {31'h0, ready}, 32'd1);
      repeat (3) @(negedge clk);
    end else begin
      repeat (7) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit expect_store,
                            input int nbits, input bit chk_lat, input bit pop_chk);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    if (expect_store) exp_q.push_back(b);
    for (int i = 0; i < nbits; i++) begin
      ps2_bit(f[i], (i == 10), chk_lat, pop_chk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic drain();
    pop_enable = 1;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    pop_enable = 0;
    chk("queue_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    chk("ready_after_drain", {31'h0, ready}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bytes9 [9];
    int         base;
    bytes9 = '{8'h1C, 8'hF0, 8'h32, 8'h29, 8'h5A, 8'h12, 8'hE0, 8'h7E, 8'h45};

    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'h0, ready}, 32'd0);
    chk("reset_data", {24'h0, data}, 32'h0);
    chk("reset_overflow", {31'h0, overflow}, 32'd0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'd0);

    // Single byte, with write-latency check.
    send_frame(8'h1C, 0, 1, 11, 1, 0);
    drain();

    // Ordering.
    send_frame(8'h1C, 0, 1, 11, 0, 0);
    send_frame(8'hF0, 0, 1, 11, 0, 0);
    send_frame(8'h1C, 0, 1, 11, 0, 0);
    drain();
    chk("no_err_on_good", err_pulses, 32'd0);

    // Parity error then recovery.
    base = err_pulses;
    send_frame(8'h1C, 1, 0, 11, 0, 0);
    repeat (4) @(negedge clk);
    chk("parity_err_pulse", err_pulses - base, 32'd1);
    chk("parity_err_ready", {31'h0, ready}, 32'd0);
    send_frame(8'h32, 0, 1, 11, 0, 0);
    drain();
    chk("err_after_recovery", err_pulses - base, 32'd1);

    // Overflow: 9th byte lost, flag sticky.
    for (int i = 0; i < 9; i++) send_frame(bytes9[i], 0, (i < 8), 11, 0, 0);
    chk("overflow_set", {31'h0, overflow}, 32'd1);
    drain();
    chk("overflow_sticky", {31'h0, overflow}, 32'd1);

    // Full FIFO with a pop in the CHECK cycle.
    do_reset();
    chk("reset_clears_overflow", {31'h0, overflow}, 32'd0);
    chk("reset_data_again", {24'h0, data}, 32'h0);
    for (int i = 0; i < 8; i++) send_frame(bytes9[i], 0, 1, 11, 0, 0);
    send_frame(bytes9[8], 0, 1, 11, 0, 1);
    chk("overflow_with_pop", {31'h0, overflow}, 32'd0);
    drain();

    // Reset mid-frame.
    send_frame(8'h55, 0, 0, 5, 0, 0);
    do_reset();
    chk("midframe_ready", {31'h0, ready}, 32'd0);
    base = err_pulses;
    send_frame(8'h29, 0, 1, 11, 0, 0);
    drain();
    chk("midframe_no_err", err_pulses - base, 32'd0);

`ifdef PS2_RX_TIMEOUT_EN
    base = err_pulses;
    send_frame(8'h77, 0, 0, 4, 0, 0);
    repeat (TO + 20) @(negedge clk);
    chk("timeout_err_pulse", err_pulses - base, 32'd1);
    chk("timeout_ready", {31'h0, ready}, 32'd0);
    send_frame(8'h5A, 0, 1, 11, 0, 0);
    drain();
    chk("timeout_recovery_err", err_pulses - base, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
